// File: rtl/mac_array_pkg.sv
// rtl/mac_array_pkg.sv - shared MAC array defaults, drain FSM states, flat-bus index helper
package mac_array_pkg;

    localparam int MAC_N     = 4;
    localparam int MAC_ACC_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_CAPT   = 2'd2,
        ST_STREAM = 2'd3
    } drain_state_t;

    // Bit offset of element (r,c) inside a row-major flat result bus.
    function automatic int res_idx(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/mac_drain_idx.sv
// rtl/mac_drain_idx.sv - row/col index counter for the result drain
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   clear               force index to (0,0)
//   advance             step to the next row-major element
//   row, col, last      registered current index; last high at (N-1,N-1)
//   succ_row, succ_col  successor of the current index (wraps to (0,0))
module mac_drain_idx
    import mac_array_pkg::*;
#(
    parameter int N = MAC_N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 advance,
    output logic [$clog2(N)-1:0] row,
    output logic [$clog2(N)-1:0] col,
    output logic                 last,
    output logic [$clog2(N)-1:0] succ_row,
    output logic [$clog2(N)-1:0] succ_col
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(N - 1);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic             last_q, last_d;

    always_comb begin
        succ_row = row_q;
        succ_col = col_q + IDX_W'(1);
        if (col_q == MAX_IDX) begin
            succ_col = '0;
            succ_row = (row_q == MAX_IDX) ? '0 : row_q + IDX_W'(1);
        end
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            row_d = succ_row;
            col_d = succ_col;
        end
        // Registered so out_last is a flop output aligned with the data word.
        last_d = (row_d == MAX_IDX) && (col_d == MAX_IDX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            last_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            last_q <= last_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = last_q;

endmodule

// File: rtl/mac_array_drain.sv
// rtl/mac_array_drain.sv - result-drain controller for the output-stationary MAC array
//
// Waits LATENCY cycles after start, snapshots the N x N results, pulses
// acc_clear and streams the snapshot row-major over valid/ready.
// Optional macro MAC_DRAIN_RELU_EN: negative words are streamed as zero.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start                tile-launch pulse from the feeder
//   res_flat             array results, element (r,c) at [(r*N+c)*ACC_W +: ACC_W]
//   acc_clear            one-cycle accumulator clear pulse
//   out_valid/out_ready  stream handshake
//   out_data             result word; out_row/out_col its index; out_last on (N-1,N-1)
//   busy                 controller not idle
//   start_err            one-cycle pulse when a start was ignored
module mac_array_drain
    import mac_array_pkg::*;
#(
    parameter int N       = MAC_N,
    parameter int ACC_W   = MAC_ACC_W,
    parameter int LATENCY = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N*N*ACC_W-1:0] res_flat,
    output logic                 acc_clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_row,
    output logic [$clog2(N)-1:0] out_col,
    output logic                 out_last,
    output logic                 busy,
    output logic                 start_err
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("mac_array_drain: LATENCY must be >= 1");
        end
        if (N < 2) begin : g_bad_n
            $error("mac_array_drain: N must be >= 2");
        end
    endgenerate

    function automatic logic [ACC_W-1:0] relu(input logic [ACC_W-1:0] w);
`ifdef MAC_DRAIN_RELU_EN
        return w[ACC_W-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    drain_state_t         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N*N*ACC_W-1:0] snap_q, snap_d;
    logic [ACC_W-1:0]     out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 acc_clear_q, acc_clear_d;
    logic                 busy_q, busy_d;
    logic                 start_err_q, start_err_d;

    logic                 idx_clear;
    logic                 idx_adv;
    logic [IDX_W-1:0]     succ_row;
    logic [IDX_W-1:0]     succ_col;
    logic                 final_hs;

    mac_drain_idx #(.N(N)) u_idx (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (idx_clear),
        .advance  (idx_adv),
        .row      (out_row),
        .col      (out_col),
        .last     (out_last),
        .succ_row (succ_row),
        .succ_col (succ_col)
    );

    // out_valid is high for the whole STREAM state, so out_ready alone completes a handshake.
    assign final_hs = (state_q == ST_STREAM) && out_ready && out_last;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        snap_d      = snap_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        acc_clear_d = 1'b0;
        start_err_d = 1'b0;
        idx_clear   = 1'b0;
        idx_adv     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            ST_WAIT: begin
                start_err_d = start;
                if (cnt_q == '0) begin
                    state_d = ST_CAPT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CAPT: begin
                start_err_d = start;
                snap_d      = res_flat;
                idx_clear   = 1'b1;
                // Word (0,0) comes straight from the bus: the snapshot is loading on the same edge.
                out_data_d  = relu(res_flat[res_idx(0, 0, N, ACC_W) +: ACC_W]);
                out_valid_d = 1'b1;
                acc_clear_d = 1'b1;
                state_d     = ST_STREAM;
            end
            ST_STREAM: begin
                start_err_d = start && !final_hs;
                if (out_ready) begin
                    idx_adv = 1'b1;
                    if (out_last) begin
                        out_valid_d = 1'b0;
                        if (start) begin
                            state_d = ST_WAIT;
                            cnt_d   = CNT_W'(LATENCY - 1);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        out_data_d = relu(snap_q[res_idx(int'(succ_row), int'(succ_col), N, ACC_W) +: ACC_W]);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            acc_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            acc_clear_q <= acc_clear_d;
            busy_q      <= busy_d;
            start_err_q <= start_err_d;
        end
    end

    // Snapshot contents are don't-care after reset; only state decides when they are read.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign acc_clear = acc_clear_q;
    assign busy      = busy_q;
    assign start_err = start_err_q;

endmodule

// File: tb/tb_mac_array_drain.sv
// tb/tb_mac_array_drain.sv - self-checking bench for mac_array_drain
module tb_mac_array_drain;
    import mac_array_pkg::*;

    localparam int N     = 4;
    localparam int ACC_W = 32;
    localparam int LAT   = 12;
    localparam int NW    = N * N;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 out_ready = 1'b0;
    logic [NW*ACC_W-1:0]  res_flat = '0;
    logic                 acc_clear, out_valid, out_last, busy, start_err;
    logic [ACC_W-1:0]     out_data;
    logic [1:0]           out_row, out_col;

    always #5 clk = ~clk;

    mac_array_drain #(.N(N), .ACC_W(ACC_W), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .res_flat  (res_flat),
        .acc_clear (acc_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .start_err (start_err)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        last;
    } exp_t;

    exp_t        tbl[NW];
    logic [31:0] tile[NW];
    exp_t        sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int c0 = 0;
    int c1 = 0;
    int clr_cnt = 0;
    int clr_last = -1;
    int err_cnt = 0;
    int last_cnt = 0;
    int last_hs_edge = -1;
    bit tog = 1'b0;
    int tog_k = 0;
    logic [3:0] pat = 4'b1001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] relu_m(input logic [31:0] w);
`ifdef MAC_DRAIN_RELU_EN
        return w[31] ? 32'h0 : w;
`else
        return w;
`endif
    endfunction

    task automatic set_tile();
        for (int i = 0; i < NW; i++) res_flat[i*ACC_W +: ACC_W] = tile[i];
    endtask

    task automatic push_exp();
        exp_t e;
        for (int i = 0; i < NW; i++) begin
            e      = tbl[i];
            e.data = relu_m(tile[i]);
            sb.push_back(e);
        end
    endtask

    // One clock: score a handshake seen before the edge, then sample after it.
    task automatic cycle();
        logic        hs, stall;
        logic [31:0] d0;
        logic [1:0]  r0, c0v;
        logic        l0;
        exp_t        e;
        if (tog) begin
            out_ready = pat[tog_k[1:0]];
            tog_k++;
        end
        hs    = out_valid && out_ready;
        stall = out_valid && !out_ready && rst_n;
        d0 = out_data; r0 = out_row; c0v = out_col; l0 = out_last;
        if (hs) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %h expected none (cycle %0d)", d0, cyc);
            end else begin
                e = sb.pop_front();
                chk("word_data", d0, e.data);
                chk("word_row", 32'(r0), 32'(e.row));
                chk("word_col", 32'(c0v), 32'(e.col));
                chk("word_last", 32'(l0), 32'(e.last));
            end
            if (l0) begin
                last_cnt++;
                last_hs_edge = cyc + 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, d0);
            chk("hold_row", 32'(out_row), 32'(r0));
            chk("hold_col", 32'(out_col), 32'(c0v));
            chk("hold_last", 32'(out_last), 32'(l0));
        end
        if (acc_clear) begin
            clr_cnt++;
            clr_last = cyc;
        end
        if (start_err) err_cnt++;
    endtask

    task automatic start_tile();
        start = 1'b1;
        push_exp();
        cycle();
        c0    = cyc;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic drain(input int budget, input int chg_at);
        int k = 0;
        while (sb.size() > 0 && k < budget) begin
            if (chg_at >= 0 && cyc - c0 == chg_at) res_flat = ~res_flat;
            cycle();
            k++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d words left expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int vcnt;
        bit second;
        int rel;
        logic [31:0] base[NW];
        base = '{32'd7, 32'd8, 32'd9, 32'd10, 32'd19, 32'd24, 32'd29, 32'd34,
                 32'd31, 32'd40, 32'd49, 32'd58, 32'd43, 32'd56, 32'd69, 32'd82};
        for (int i = 0; i < NW; i++) begin
            tbl[i].data = base[i];
            tbl[i].row  = 2'(i / N);
            tbl[i].col  = 2'(i % N);
            tbl[i].last = (i == NW - 1);
        end

        // Reset state
        idle(3);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_row", 32'(out_row), 32'd0);
        chk("rst_out_col", 32'(out_col), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_acc_clear", 32'(acc_clear), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start_err", 32'(start_err), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Basic tile, ready held high
        tile = base;
        set_tile();
        out_ready = 1'b1;
        clr_cnt = 0; last_cnt = 0; err_cnt = 0;
        start_tile();
        drain(100, -1);
        chk("t1_acc_clear_count", 32'(clr_cnt), 32'd1);
        chk("t1_acc_clear_cycle", 32'(clr_last), 32'(c0 + LAT + 1));
        chk("t1_last_count", 32'(last_cnt), 32'd1);
        chk("t1_final_edge", 32'(last_hs_edge), 32'(c0 + LAT + 1 + NW));
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_valid_after", 32'(out_valid), 32'd0);
        chk("t1_no_start_err", 32'(err_cnt), 32'd0);
        idle(3);

        // Backpressure 1,0,0,1,...
        clr_cnt = 0;
        tog = 1'b1; tog_k = 0;
        start_tile();
        drain(200, -1);
        tog = 1'b0;
        out_ready = 1'b1;
        chk("t2_acc_clear_count", 32'(clr_cnt), 32'd1);
        idle(3);
        chk("t2_busy_after", 32'(busy), 32'd0);

        // Ignored starts, then back-to-back start on final handshake
        clr_cnt = 0; err_cnt = 0; second = 1'b0; k = 0;
        start_tile();
        while ((sb.size() > 0 || busy) && k < 150) begin
            rel = cyc - c0;
            start = (rel == 3) || (rel == 20);
            if (!second && out_valid && out_last && out_ready) begin
                start  = 1'b1;
                second = 1'b1;
                c1     = cyc + 1;
                for (int i = 0; i < NW; i++) tile[i] = base[i] + 32'd100;
                set_tile();
                push_exp();
            end
            cycle();
            k++;
        end
        start = 1'b0;
        chk("t3_busy_done", 32'(busy), 32'd0);
        chk("t3_words_left", 32'(sb.size()), 32'd0);
        sb.delete();
        chk("t3_second_started", 32'(second), 32'd1);
        chk("t3_start_err_count", 32'(err_cnt), 32'd2);
        chk("t3_acc_clear_count", 32'(clr_cnt), 32'd2);
        chk("t3_b2b_clear_cycle", 32'(clr_last), 32'(c1 + LAT + 1));
        idle(3);

        // Reset after the 5th word
        tile = base;
        set_tile();
        start_tile();
        k = 0;
        while (NW - sb.size() < 5 && k < 60) begin
            cycle();
            k++;
        end
        chk("t4_five_words", 32'(NW - sb.size()), 32'd5);
        rst_n = 1'b0;
        out_ready = 1'b0;
        cycle();
        sb.delete();
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_out_data", out_data, 32'd0);
        chk("t4_out_row", 32'(out_row), 32'd0);
        chk("t4_out_col", 32'(out_col), 32'd0);
        chk("t4_out_last", 32'(out_last), 32'd0);
        chk("t4_acc_clear", 32'(acc_clear), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_start_err", 32'(start_err), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        clr_cnt = 0; vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (out_valid) vcnt++;
        end
        chk("t4_no_valid_after", 32'(vcnt), 32'd0);
        chk("t4_no_clear_after", 32'(clr_cnt), 32'd0);

        // Negative word (0,0)
        tile = base;
        tile[0] = 32'hFFFF_FFF9;
        set_tile();
        start_tile();
        drain(100, -1);
        idle(3);

        // Snapshot isolation: bus changes after capture
        for (int i = 0; i < NW; i++) tile[i] = base[i] + 32'd200;
        set_tile();
        start_tile();
        drain(100, LAT + 1);
        chk("t6_bus_changed", res_flat[31:0], ~tile[0]);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
